// File: rtl/pagerank_pkg.sv
// Shared constants for the pagerank update stage: Q16.16 format, default
// damping/base/initial-rank values, FSM state codes and a saturating adder.
package pagerank_pkg;

  localparam int Q_W    = 32;
  localparam int Q_FRAC = 16;

  localparam logic [Q_W-1:0] DAMP_DEF      = 32'h0000D99A;  // d = 0.85
  localparam logic [Q_W-1:0] BASE_DEF      = 32'h000003D7;  // (1-d)/N = 0.015
  localparam logic [Q_W-1:0] INIT_RANK_DEF = 32'h0000199A;  // 1/N
  localparam logic [Q_W-1:0] EPS_DEF       = 32'h00000010;

  // FSM state codes, also visible on the debug state output.
  localparam int         ST_W     = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Unsigned add that clamps to all-ones instead of wrapping.
  function automatic logic [Q_W-1:0] sat_add(input logic [Q_W-1:0] a,
                                             input logic [Q_W-1:0] b);
    logic [Q_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[Q_W] ? '1 : s[Q_W-1:0];
  endfunction

endpackage

// File: rtl/pagerank_update_if.sv
// Stream interface of the pagerank update stage: summed contributions in,
// updated ranks out.
//
// Handshake (both directions): a beat transfers on a rising edge where
// valid && ready. The source holds valid and its payload stable until the
// transfer; ready may depend on the sink's state but valid never depends on
// ready.
interface pagerank_update_if #(
  parameter int IDX_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic [31:0]      in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [31:0]      out_rank;

  // Producer of sums and consumer of ranks.
  modport master (
    output in_valid, in_idx, in_sum, out_ready,
    input  in_ready, out_valid, out_idx, out_rank
  );

  // The update stage itself.
  modport slave (
    input  in_valid, in_idx, in_sum, out_ready,
    output in_ready, out_valid, out_idx, out_rank
  );

endinterface

// File: rtl/pr_fixmul_sat.sv
// Q16.16 x Q16.16 unsigned multiply, result clamped to all-ones when the
// integer part overflows 16 bits.
module pr_fixmul_sat
  import pagerank_pkg::*;
(
  input  logic [Q_W-1:0] a,
  input  logic [Q_W-1:0] b,
  output logic [Q_W-1:0] y
);

  localparam int P_W  = 2 * Q_W;
  localparam int SH_W = P_W - Q_FRAC;

  logic [P_W-1:0]  p;
  logic [SH_W-1:0] p_sh;

  assign p    = {{Q_W{1'b0}}, a} * {{Q_W{1'b0}}, b};
  assign p_sh = SH_W'(p >> Q_FRAC);
  assign y    = (|p_sh[SH_W-1:Q_W]) ? '1 : p_sh[Q_W-1:0];

endmodule

// File: rtl/pagerank_update.sv
// Pagerank update stage: damps each summed contribution into a new rank,
// stores it in the rank table, streams it out and runs the iteration loop
// until the max per-iteration rank change drops to EPS or MAX_ITER is hit.
// Two-stage pipe: S1 registers the damped product, S2 (output register)
// adds BASE, writes the table and folds |new-old| into max_delta.
module pagerank_update
  import pagerank_pkg::*;
#(
  parameter int          N_NODES   = 10,
  parameter int          IDX_W     = 4,
  parameter int          ITER_W    = 8,
  parameter int          MAX_ITER  = 50,
  parameter logic [31:0] DAMP      = DAMP_DEF,
  parameter logic [31:0] BASE      = BASE_DEF,
  parameter logic [31:0] INIT_RANK = INIT_RANK_DEF,
  parameter logic [31:0] EPS       = EPS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  pagerank_update_if.slave  bus,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              idx_err,
  output logic [ST_W-1:0]   dbg_state
);

  localparam int          CNT_W     = $clog2(N_NODES + 1);
  localparam logic [31:0] N_NODES_U = N_NODES;

  logic [ST_W-1:0]  state;
  logic [31:0]      rank_tbl [N_NODES];
  logic [N_NODES-1:0] seen;
  logic [CNT_W-1:0] seen_cnt;
  logic [31:0]      max_delta;

  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;
  logic [31:0]      s1_m;

  logic        advance, in_fire, idx_bad, s1_commit, pipe_empty, all_seen, start_ok;
  logic [31:0] mul_y, r_new, old_rank, delta;

  // The whole pipe moves only when the output register can take new data.
  assign advance    = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state == ST_RUN) && advance;
  assign in_fire    = bus.in_valid && bus.in_ready;
  assign idx_bad    = {{(32-IDX_W){1'b0}}, bus.in_idx} >= N_NODES_U;
  assign s1_commit  = advance && s1_valid;
  // A beat being accepted this cycle still counts as in flight.
  assign pipe_empty = !s1_valid && !bus.out_valid && !in_fire;
  assign all_seen   = (seen_cnt == CNT_W'(N_NODES));
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));

  assign busy      = (state == ST_RUN) || (state == ST_CHECK);
  assign dbg_state = state;

  pr_fixmul_sat u_mul (
    .a (bus.in_sum),
    .b (DAMP),
    .y (mul_y)
  );

  assign r_new    = sat_add(s1_m, BASE);
  assign old_rank = rank_tbl[s1_idx];
  assign delta    = (r_new >= old_rank) ? (r_new - old_rank) : (old_rank - r_new);

  // S1: capture the damped product; out-of-range beats are consumed but dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_m     <= '0;
    end else if (advance) begin
      s1_valid <= in_fire && !idx_bad;
      s1_idx   <= bus.in_idx;
      s1_m     <= mul_y;
    end
  end

  // S2: output register, holds stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_rank  <= '0;
    end else if (advance) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_idx  <= s1_idx;
        bus.out_rank <= r_new;
      end
    end
  end

  // Rank table: reloaded on start, written as each beat leaves S1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) rank_tbl[i] <= INIT_RANK;
    end else if (start_ok) begin
      for (int i = 0; i < N_NODES; i++) rank_tbl[i] <= INIT_RANK;
    end else if (s1_commit) begin
      rank_tbl[s1_idx] <= r_new;
    end
  end

  // Iteration control: FSM, seen bitmap/count, max delta and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      iter_count <= '0;
      done       <= 1'b0;
      converged  <= 1'b0;
      idx_err    <= 1'b0;
      seen       <= '0;
      seen_cnt   <= '0;
      max_delta  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state      <= ST_RUN;
            iter_count <= '0;
            idx_err    <= 1'b0;
            converged  <= 1'b0;
            seen       <= '0;
            seen_cnt   <= '0;
            max_delta  <= '0;
          end
        end
        ST_RUN: begin
          if (all_seen && pipe_empty) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (max_delta <= EPS) begin
            state     <= ST_DONE;
            converged <= 1'b1;
            done      <= 1'b1;
          end else if ((iter_count + ITER_W'(1)) == ITER_W'(MAX_ITER)) begin
            state     <= ST_DONE;
            converged <= 1'b0;
            done      <= 1'b1;
          end else begin
            state      <= ST_RUN;
            iter_count <= iter_count + ITER_W'(1);
            seen       <= '0;
            seen_cnt   <= '0;
            max_delta  <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (in_fire && idx_bad) idx_err <= 1'b1;
      // Beats only commit in RUN, so this never collides with the clears above.
      if (s1_commit) begin
        if (!seen[s1_idx]) begin
          seen[s1_idx] <= 1'b1;
          seen_cnt     <= seen_cnt + CNT_W'(1);
        end
        if (delta > max_delta) max_delta <= delta;
      end
    end
  end

endmodule

// File: tb/tb_pagerank_update.sv
// Bench for pagerank_update: directed vectors, multi-cycle corner sequences
// and randomized iterations checked against a behavioural rank model.
module tb_pagerank_update;
  import pagerank_pkg::*;

  localparam int N    = 10;
  localparam int IW   = 4;
  localparam int MAXI = 3;

  typedef struct {
    logic [IW-1:0] idx;
    logic [31:0]   sum;
    logic [31:0]   exp_rank;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] iter_count;
  logic       busy, done, converged, idx_err;
  logic [1:0] dbg_state;

  pagerank_update_if #(.IDX_W(IW)) bus ();

  pagerank_update #(
    .N_NODES (N),
    .IDX_W   (IW),
    .ITER_W  (8),
    .MAX_ITER(MAXI)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .iter_count(iter_count),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .idx_err   (idx_err),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [IW+31:0] exp_q[$];

  // Behavioural model state.
  logic [31:0] m_tbl [N];
  logic [N-1:0] m_seen;
  logic [31:0] m_md;
  int          m_iter;
  bit          m_done;
  bit          m_err;
  bit          rand_ready = 0;

  function automatic logic [31:0] model_rank(input logic [31:0] sum);
    longint unsigned p, m, r;
    p = 64'(sum) * 64'(DAMP_DEF);
    m = p / 65536;
    if (m > 64'hFFFF_FFFF) m = 64'hFFFF_FFFF;
    r = m + 64'(BASE_DEF);
    if (r > 64'hFFFF_FFFF) r = 64'hFFFF_FFFF;
    return r[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every output transfer must match the head of the expected queue.
  always @(negedge clk) begin : mon
    logic [IW+31:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got idx %0d rank %0h required no beat",
                 bus.out_idx, bus.out_rank);
      end else begin
        e = exp_q.pop_front();
        check("out_beat", {bus.out_idx, bus.out_rank}, e);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_tbl[i] = INIT_RANK_DEF;
    m_seen = '0;
    m_md   = '0;
    m_iter = 0;
    m_done = 0;
    m_err  = 0;
  endtask

  // Drivers.
  task automatic drive_beat(input logic [IW-1:0] idx, input logic [31:0] sum,
                            input logic [31:0] exp_rank);
    logic [31:0] d;
    bus.in_valid = 1'b1;
    bus.in_idx   = idx;
    bus.in_sum   = sum;
    if (idx < N) begin
      d = (exp_rank >= m_tbl[idx]) ? exp_rank - m_tbl[idx] : m_tbl[idx] - exp_rank;
      if (d > m_md) m_md = d;
      m_tbl[idx]  = exp_rank;
      m_seen[idx] = 1'b1;
      exp_q.push_back({idx, exp_rank});
    end else begin
      m_err = 1;
    end
  endtask

  task automatic wait_accept();
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    while (!ok && n < 60) begin
      @(negedge clk);
      n++;
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic send_beat(input logic [IW-1:0] idx, input logic [31:0] sum);
    drive_beat(idx, sum, model_rank(sum));
    wait_accept();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_reset();
    check("start_busy", busy, 1);
    check("start_iter", iter_count, 0);
    check("start_idx_err", idx_err, 0);
    check("start_converged", converged, 0);
  endtask

  // Close an iteration in the model and check the DUT takes the same branch.
  task automatic end_iter();
    bit fin, exp_conv, got;
    int n;
    logic [7:0] want;
    bus.out_ready = 1'b1;
    fin = 0;
    exp_conv = 0;
    if (m_md <= EPS_DEF) begin
      fin = 1;
      exp_conv = 1;
    end else if (m_iter + 1 == MAXI) begin
      fin = 1;
    end
    got = 0;
    n   = 0;
    if (fin) begin
      while (!got && n < 40) begin
        @(negedge clk);
        n++;
        got = done;
      end
      check("done_pulse", got, 1);
      check("done_converged", converged, exp_conv);
      check("done_iter_count", iter_count, m_iter);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("done_not_busy", busy, 0);
      m_done = 1;
    end else begin
      m_iter++;
      want = m_iter[7:0];
      while (!got && n < 40) begin
        @(negedge clk);
        n++;
        got = (iter_count == want);
      end
      check("iter_advance", got, 1);
      check("iter_no_done", done, 0);
      m_seen = '0;
      m_md   = '0;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[6];
  logic [31:0] exp6;
  bit conv_mode;

  initial begin
    vecs[0] = '{4'd0, 32'h0001_0000, 32'h0000_DD71};
    vecs[1] = '{4'd1, 32'hFFFF_FFFF, 32'hD99A_03D6};
    vecs[2] = '{4'd2, 32'h0000_0000, 32'h0000_03D7};
    vecs[3] = '{4'd3, 32'h0000_199A, 32'h0000_1999};
    vecs[4] = '{4'd4, 32'h0002_0000, 32'h0001_B70B};
    vecs[5] = '{4'd5, 32'h0005_0000, 32'h0004_43D9};

    bus.in_valid  = 1'b0;
    bus.in_idx    = '0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b1;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_iter", iter_count, 0);
    check("rst_idx_err", idx_err, 0);
    check("rst_converged", converged, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Iteration 0: directed vectors, latency, bad index, duplicate, stall.
    do_start();
    for (int i = 0; i < 6; i++) begin
      drive_beat(vecs[i].idx, vecs[i].sum, vecs[i].exp_rank);
      wait_accept();
      if (i == 0) begin
        @(negedge clk);
        check("lat_cycle1", bus.out_valid, 0);
        @(negedge clk);
        check("lat_cycle2", bus.out_valid, 1);
        check("lat_idx", bus.out_idx, 0);
        @(posedge clk);
        #1;
      end
    end
    send_beat(4'd12, 32'h0000_1234);
    repeat (4) @(negedge clk);
    check("idx_err_set", idx_err, 1);
    @(posedge clk);
    #1;
    send_beat(4'd3, 32'h0003_0000);
    repeat (3) @(posedge clk);
    #1;
    check("idx_err_sticky", idx_err, 1);

    bus.out_ready = 1'b0;
    exp6 = model_rank(32'h0001_1111);
    send_beat(4'd6, 32'h0001_1111);
    send_beat(4'd7, 32'h0000_7777);
    drive_beat(4'd8, 32'h0000_4444, model_rank(32'h0000_4444));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_rank", bus.out_rank, exp6);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_accept();
    repeat (6) @(negedge clk);
    check("no_check_before_all_seen", dbg_state, ST_RUN);
    @(posedge clk);
    #1;
    send_beat(4'd9, 32'h0000_8000);
    end_iter();

    // Iterations 1 and 2: alternating sums, then MAX_ITER stop.
    for (int i = 0; i < N; i++) send_beat(i[IW-1:0], 32'h0001_0000);
    end_iter();
    for (int i = 0; i < N; i++) send_beat(i[IW-1:0], 32'h0000_0000);
    end_iter();
    check("maxiter_reached", m_done, 1);

    // Convergence on the first iteration.
    do_start();
    for (int i = 0; i < N; i++) send_beat(i[IW-1:0], 32'h0000_199A);
    end_iter();
    check("converge_reached", m_done, 1);

    // Reset in the middle of an iteration with a stalled beat pending.
    do_start();
    bus.out_ready = 1'b0;
    send_beat(4'd0, 32'h0000_5000);
    send_beat(4'd1, 32'h0000_6000);
    @(negedge clk);
    check("pre_reset_hold", bus.out_valid, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    exp_q.delete();
    model_reset();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized iterations with random back-pressure.
    do_start();
    rand_ready = 1;
    conv_mode  = 1;
    for (int b = 0; b < 90; b++) begin
      logic [IW-1:0] idx;
      logic [31:0]   sum;
      idx = IW'($urandom_range(0, 11));
      sum = conv_mode ? (32'h0000_1999 + 32'($urandom_range(0, 1))) : $urandom();
      send_beat(idx, sum);
      if (&m_seen) begin
        end_iter();
        if (m_done) do_start();
        conv_mode = ($urandom_range(0, 1) == 1);
      end
    end
    rand_ready = 0;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("rand_idx_err", idx_err, m_err);
    check("rand_iter_count", iter_count, m_iter);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
